// File: rtl/tone_phase_scheduler.sv
// Time-multiplexed DDS phase engine: one shared adder steps NUM_CH tone phases, one channel per clock, on each sample tick.
// Optional hard sync (addr 9 clears selected phases) is built only when TONE_HARD_SYNC_EN is defined.
module tone_phase_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2,
    parameter int PHASE_W = 16,
    parameter int MC_W    = 10
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [MC_W-1:0]    master_count_in,
    input  logic [15:0]        data_in,
    input  logic [3:0]         addr_in,
    input  logic               data_valid_in,
    output logic [PHASE_W-1:0] phase_out,
    output logic [CH_BITS-1:0] ch_out,
    output logic               phase_valid_out,
    output logic               busy_out,
    output logic [NUM_CH-1:0]  enable_out
);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                         r_state;
    logic [CH_BITS-1:0]             r_ch_idx;
    logic                           r_busy;
    logic [NUM_CH-1:0][PHASE_W-1:0] r_phase;
    logic [NUM_CH-1:0][PHASE_W-1:0] r_incr;
    logic [NUM_CH-1:0]              r_enable;
    logic [PHASE_W-1:0]             r_phase_out;
    logic [CH_BITS-1:0]             r_ch_out;
    logic                           r_valid;

    logic [NUM_CH-1:0] w_incr_we;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_upd;
    logic              w_mask_we;
    logic              w_sweep;
    logic [PHASE_W-1:0] w_sum;
    logic [PHASE_W-1:0] w_slot_val;

    assign w_mask_we = data_valid_in && (addr_in == 4'd8);
    assign w_sweep   = (r_state == S_SWEEP);
    // Shared adder; accumulation always sees the incr held before any same-cycle write.
    assign w_sum     = r_phase[r_ch_idx] + r_incr[r_ch_idx];

`ifdef TONE_HARD_SYNC_EN
    logic [NUM_CH-1:0] w_sync;
    always_comb begin
        w_sync = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_sync[c] = data_valid_in && (addr_in == 4'd9) && data_in[c];
    end
    assign w_slot_val = w_sync[r_ch_idx] ? '0 : w_sum;
`else
    assign w_slot_val = w_sum;
`endif

    always_comb begin
        w_incr_we = '0;
        w_clr     = '0;
        w_upd     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_incr_we[c] = data_valid_in && (addr_in == 4'(c));
            // A channel dropped from the mask restarts from zero when re-enabled.
            w_clr[c]     = w_mask_we && r_enable[c] && !data_in[c];
`ifdef TONE_HARD_SYNC_EN
            w_clr[c]     = w_clr[c] || w_sync[c];
`endif
            w_upd[c]     = w_sweep && (r_ch_idx == CH_BITS'(c)) && r_enable[c];
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_phase  <= '0;
            r_incr   <= '0;
            r_enable <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_incr_we[c])
                    r_incr[c] <= data_in[PHASE_W-1:0];
                if (w_clr[c])
                    r_phase[c] <= '0;
                else if (w_upd[c])
                    r_phase[c] <= w_sum;
            end
            if (w_mask_we)
                r_enable <= data_in[NUM_CH-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= S_IDLE;
            r_ch_idx    <= '0;
            r_busy      <= 1'b0;
            r_phase_out <= '0;
            r_ch_out    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (master_count_in == '0) begin
                        r_state  <= S_SWEEP;
                        r_ch_idx <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (r_enable[r_ch_idx]) begin
                        r_phase_out <= w_slot_val;
                        r_ch_out    <= r_ch_idx;
                        r_valid     <= 1'b1;
                    end
                    if (r_ch_idx == CH_BITS'(NUM_CH - 1)) begin
                        r_state  <= S_IDLE;
                        r_ch_idx <= '0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_ch_idx <= r_ch_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign phase_out       = r_phase_out;
    assign ch_out          = r_ch_out;
    assign phase_valid_out = r_valid;
    assign busy_out        = r_busy;
    assign enable_out      = r_enable;

endmodule
